sme_unmask_seq: RTL and testbench
=================================

Name: sme_unmask_seq

Overview:
- Sequential share-recombination (unmasking) unit for SME: the reverse direction of share generation and masking.
- Accepts an SMAX-share masked word and folds the shares into one plaintext word, one share per cycle, so no single cycle combines more than two shares.
- Boolean (XOR) or arithmetic (add mod 2^XLEN) recombination, selected per operation by smectl_t.
- Sits beside the SME ALU on the result path; feeds unmasked values back to the integer pipeline through a valid/ready result handshake.

Parameters:
- XLEN, 32, data width of each share.
- SMAX, 4, maximum number of hardware shares; legal range 2..15.

Ports:
- Clock and reset: one clock, g_clk; reset g_reset is synchronous and active-high.
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous active-high reset.
- smectl_t  in  1  masking type: 0 = boolean, 1 = arithmetic; sampled on accept.
- smectl_d  in  4  number of shares in use; sampled on accept.
- flush  in  1  abandon the current operation; discard all state.
- valid  in  1  input operation valid.
- ready  out  1  unit can accept an operation.
- rs1  in  SMAX x XLEN  input shares, unpacked array [SMAX-1:0].
- result_valid  out  1  unmasked result available.
- result_ready  in  1  consumer accepts the result.
- result  out  XLEN  unmasked word; all-zero whenever result_valid = 0.

Behaviour:
- Reset values: state IDLE, ready = 1, result_valid = 0, result = 0, accumulator = 0, share buffer = 0, index = 0.
  - While g_reset = 1, valid is ignored.
- Effective share count d_eff:
  - smectl_d = 0 -> d_eff = 1.
  - smectl_d > SMAX -> d_eff = SMAX.
  - otherwise d_eff = smectl_d.
- Accept: valid && ready && !flush.
  - Latch t = smectl_t and d_eff.
  - acc <= rs1[0].
  - buf[i] <= rs1[i] for 1 <= i < d_eff; buf[i] <= 0 for i >= d_eff.
  - idx <= 1.
- State IDLE: ready = 1.
  - On accept: go to DONE if d_eff = 1, else go to FOLD.
- State FOLD: ready = 0. Each cycle:
  - acc <= t ? acc + buf[idx] : acc ^ buf[idx].
  - buf[idx] <= 0 (consumed shares are zeroised).
  - idx <= idx + 1.
  - When idx == d_eff-1, go to DONE on the same edge.
- State DONE: result_valid = 1, result = acc, ready = 0.
  - On result_ready: acc <= 0, go to IDLE.
  - No new input is accepted in the cycle the result is consumed.
- Latency: with acceptance in cycle 0, result_valid rises in cycle d_eff.
  - Back-to-back issue rate: one operation per d_eff+1 cycles, plus any stall cycles.
- Backpressure: in DONE with result_ready = 0, result, result_valid and all state hold indefinitely.
- Arithmetic: addition wraps modulo 2^XLEN; no carry-out is kept.
- flush: in any state, return to IDLE next cycle and clear acc, buf and idx to 0.
  - No result is produced.
  - flush beats valid in the same cycle: nothing is accepted.
  - flush beats result_ready in DONE: the result is dropped.
- Reset mid-operation: identical to flush; ready is 1 in the first cycle after reset deasserts.
- Input shares are not required to stay stable after accept.
- result must never expose acc outside DONE, including partial folds.

Decomposition:
- Shared package sme_pkg holds:
  - the state enum sme_unmask_state_t {IDLE, FOLD, DONE};
  - the d_eff clamp as a function;
  - default XLEN/SMAX localparams.
- One combinational sub-module, sme_fold_step (inputs t, acc, share; output next acc), so the same XOR/add step can be reused for later A2B/B2A converters.
- Everything else stays in sme_unmask_seq.

Test Plan:
- Boolean, d=2: rs1[0]=0x12345678, rs1[1]=0xFFFF0000, result_ready=1 -> result_valid in cycle 2, result=0xEDCB5678, ready back to 1 in cycle 3.
- Arithmetic, d=3: shares 0xFFFFFFFF, 0x00000002, 0x10000000 -> result=0x10000001 in cycle 3 (wrap checked); result=0 in cycles 1-2.
- Clamping:
  - smectl_d=0, rs1[0]=0xA5A5A5A5 -> result=0xA5A5A5A5 in cycle 1.
  - smectl_d=9, boolean, shares 1,2,4,8 -> result=0x0000000F in cycle 4.
- Backpressure: d=4, result_ready low 3 cycles after result_valid -> result and result_valid stable, ready=0, a valid pulse during the stall is ignored; the result is consumed on the 4th cycle.
- Flush mid-FOLD (d=4, flush in cycle 2) -> IDLE in cycle 3, result_valid never asserted, internal buf/acc = 0, a next op with d=2 completes correctly.
- g_reset asserted in cycle 2 of a d=4 op, together with valid -> no result, no accept during reset, ready=1 the cycle after release.

Source files
------------

// File: rtl/sme_pkg.sv
// sme_pkg: shared states, defaults and share-count clamp for the SME unmasking datapath
package sme_pkg;
   localparam int XLEN_D = 32;
   localparam int SMAX_D = 4;
   typedef enum logic [1:0] {IDLE, FOLD, DONE} sme_unmask_state_t;
   function automatic logic [3:0] d_clamp(input logic [3:0] d, input int smax);
      return d == 4'd0 ? 4'd1 : int'(d) > smax ? 4'(smax) : d;
   endfunction
endpackage

// File: rtl/sme_fold_step.sv
// sme_fold_step: one share recombination step, XOR (boolean) or add mod 2^XLEN (arithmetic)
module sme_fold_step
   import sme_pkg::*;
#(
   parameter int XLEN = XLEN_D
) (
   input  logic            t,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] share,
   output logic [XLEN-1:0] nxt
);
   assign nxt = t ? acc + share : acc ^ share;
endmodule

// File: rtl/sme_unmask_seq.sv
// sme_unmask_seq: folds an SMAX-share masked word into plaintext, one share per cycle
module sme_unmask_seq
   import sme_pkg::*;
#(
   parameter int XLEN = XLEN_D,
   parameter int SMAX = SMAX_D
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            smectl_t,
   input  logic [3:0]      smectl_d,
   input  logic            flush,
   input  logic            valid,
   output logic            ready,
   input  logic [XLEN-1:0] rs1 [SMAX-1:0],
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result
);
   sme_unmask_state_t state, state_nxt;
   logic [XLEN-1:0] acc, acc_nxt, share;
   logic [XLEN-1:0] shr [SMAX-1:0];
   logic [3:0] idx, d_q, d_eff;
   logic t_q, accept;
   assign d_eff = d_clamp(smectl_d, SMAX);
   assign ready = state == IDLE;
   assign accept = valid && ready && !flush;
   assign result_valid = state == DONE;
   // partial folds stay hidden: acc is only visible once complete
   assign result = result_valid ? acc : '0;
   sme_fold_step #(.XLEN(XLEN)) u_step (.t(t_q), .acc(acc), .share(share), .nxt(acc_nxt));
   always_comb begin
      share = '0;
      for (int i = 0; i < SMAX; i++) share = idx == 4'(i) ? shr[i] : share;
      state_nxt = flush ? IDLE :
                  state == IDLE ? (accept ? (d_eff == 4'd1 ? DONE : FOLD) : IDLE) :
                  state == FOLD ? (idx == d_q - 4'd1 ? DONE : FOLD) :
                  (result_ready ? IDLE : DONE);
   end
   always_ff @(posedge g_clk) state <= g_reset ? IDLE : state_nxt;
   always_ff @(posedge g_clk) begin
      if (g_reset || flush) begin
         acc <= '0;
         idx <= '0;
         t_q <= 1'b0;
         d_q <= '0;
         for (int i = 0; i < SMAX; i++) shr[i] <= '0;
      end else if (accept) begin
         t_q <= smectl_t;
         d_q <= d_eff;
         acc <= rs1[0];
         idx <= 4'd1;
         for (int i = 0; i < SMAX; i++) shr[i] <= i > 0 && 4'(i) < d_eff ? rs1[i] : '0;
      end else if (state == FOLD) begin
         acc <= acc_nxt;
         idx <= idx + 4'd1;
         // consumed shares are zeroised
         for (int i = 0; i < SMAX; i++) if (idx == 4'(i)) shr[i] <= '0;
      end else if (state == DONE && result_ready) begin
         acc <= '0;
      end
   end
endmodule

// File: tb/tb_sme_unmask_seq.sv
// tb_sme_unmask_seq: vector table, random ops against a fold model, and stall/flush/reset sequences
module tb_sme_unmask_seq;
   logic g_clk = 1'b0, g_reset = 1'b1, smectl_t = 1'b0, flush = 1'b0, valid = 1'b0, result_ready = 1'b1;
   logic [3:0] smectl_d = '0;
   logic [31:0] rs1 [3:0];
   logic ready, result_valid;
   logic [31:0] result;
   int n_chk = 0, n_fail = 0;

   typedef struct packed {
      logic t;
      logic [3:0] d;
      logic [3:0][31:0] sh;
      logic [31:0] res;
      logic [3:0] lat;
   } vec_t;
   vec_t tbl [7];

   sme_unmask_seq #(.XLEN(32), .SMAX(4)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .smectl_t(smectl_t), .smectl_d(smectl_d), .flush(flush),
      .valid(valid), .ready(ready), .rs1(rs1), .result_valid(result_valid),
      .result_ready(result_ready), .result(result)
   );

   always #5 g_clk = ~g_clk;

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_shares(input logic [3:0][31:0] sh);
      for (int i = 0; i < 4; i++) rs1[i] = sh[i];
   endtask

   task automatic scramble();
      for (int i = 0; i < 4; i++) rs1[i] = $urandom;
   endtask

   function automatic logic [31:0] model(input logic t, input logic [3:0] d, input logic [3:0][31:0] sh);
      int n;
      logic [31:0] a;
      n = d == 0 ? 1 : d > 4 ? 4 : int'(d);
      a = sh[0];
      for (int i = 1; i < n; i++) a = t ? a + sh[i] : a ^ sh[i];
      return a;
   endfunction

   task automatic run_op(input logic t, input logic [3:0] d, input logic [3:0][31:0] sh,
                         output logic [31:0] res, output int lat);
      result_ready = 1'b1;
      chk("ready_before_accept", 32'(ready), 32'd1);
      smectl_t = t;
      smectl_d = d;
      set_shares(sh);
      valid = 1'b1;
      step();
      valid = 1'b0;
      scramble();
      lat = 1;
      while (!result_valid && lat < 40) begin
         chk("result_hidden_during_fold", result, 32'd0);
         chk("ready_low_during_fold", 32'(ready), 32'd0);
         step();
         lat++;
      end
      chk("result_valid_timeout", 32'(result_valid), 32'd1);
      res = result;
      step();
      chk("ready_after_consume", 32'(ready), 32'd1);
      chk("result_valid_after_consume", 32'(result_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] res, held;
      logic [3:0][31:0] sh;
      logic t;
      logic [3:0] d;
      int lat;
      tbl[0] = '{1'b0, 4'd2, {32'h0, 32'h0, 32'hFFFF0000, 32'h12345678}, 32'hEDCB5678, 4'd2};
      tbl[1] = '{1'b1, 4'd3, {32'h0, 32'h10000000, 32'h00000002, 32'hFFFFFFFF}, 32'h10000001, 4'd3};
      tbl[2] = '{1'b0, 4'd0, {32'h11111111, 32'h22222222, 32'h33333333, 32'hA5A5A5A5}, 32'hA5A5A5A5, 4'd1};
      tbl[3] = '{1'b0, 4'd9, {32'h8, 32'h4, 32'h2, 32'h1}, 32'h0000000F, 4'd4};
      tbl[4] = '{1'b1, 4'd4, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h0000000A, 4'd4};
      tbl[5] = '{1'b0, 4'd1, {32'hDEAD, 32'hBEEF, 32'hFF, 32'h55}, 32'h00000055, 4'd1};
      tbl[6] = '{1'b1, 4'd15, {32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000}, 32'h0, 4'd4};
      scramble();
      step();
      step();
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_result_valid", 32'(result_valid), 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_acc", dut.acc, 32'd0);
      g_reset = 1'b0;
      step();
      for (int k = 0; k < 7; k++) begin
         run_op(tbl[k].t, tbl[k].d, tbl[k].sh, res, lat);
         chk($sformatf("vec%0d_result", k), res, tbl[k].res);
         chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(tbl[k].lat));
      end
      for (int k = 0; k < 40; k++) begin
         t = 1'($urandom);
         d = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) sh[i] = $urandom;
         run_op(t, d, sh, res, lat);
         chk("rand_result", res, model(t, d, sh));
         chk("rand_latency", 32'(lat), 32'(d == 0 ? 1 : d > 4 ? 4 : d));
      end
      // backpressure: hold result for three cycles, ignore a valid pulse meanwhile
      sh = {32'h4, 32'h3, 32'h2, 32'h1};
      smectl_t = 1'b0;
      smectl_d = 4'd4;
      set_shares(sh);
      result_ready = 1'b0;
      valid = 1'b1;
      step();
      valid = 1'b0;
      for (int c = 1; c < 4; c++) step();
      chk("bp_valid_at_latency", 32'(result_valid), 32'd1);
      held = result;
      chk("bp_result", held, 32'h4);
      for (int c = 0; c < 3; c++) begin
         valid = c == 1;
         smectl_d = 4'd1;
         scramble();
         step();
         chk("bp_hold_result", result, held);
         chk("bp_hold_valid", 32'(result_valid), 32'd1);
         chk("bp_ready_low", 32'(ready), 32'd0);
      end
      valid = 1'b0;
      result_ready = 1'b1;
      step();
      chk("bp_consumed", 32'(result_valid), 32'd0);
      chk("bp_ready_back", 32'(ready), 32'd1);
      // flush mid-fold
      smectl_t = 1'b1;
      smectl_d = 4'd4;
      set_shares({32'h9, 32'h7, 32'h5, 32'h3});
      valid = 1'b1;
      step();
      valid = 1'b0;
      chk("fl_result_valid_c1", 32'(result_valid), 32'd0);
      step();
      flush = 1'b1;
      chk("fl_result_valid_c2", 32'(result_valid), 32'd0);
      step();
      flush = 1'b0;
      chk("fl_idle_ready", 32'(ready), 32'd1);
      chk("fl_result_valid_c3", 32'(result_valid), 32'd0);
      chk("fl_acc_clear", dut.acc, 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("fl_buf%0d_clear", i), dut.shr[i], 32'd0);
      run_op(1'b0, 4'd2, {32'h0, 32'h0, 32'h0F0F0F0F, 32'hFFFF0000}, res, lat);
      chk("fl_next_result", res, 32'hF0F00F0F);
      chk("fl_next_latency", 32'(lat), 32'd2);
      // flush beats valid in IDLE
      valid = 1'b1;
      flush = 1'b1;
      step();
      valid = 1'b0;
      flush = 1'b0;
      chk("flv_not_accepted", 32'(ready), 32'd1);
      step();
      chk("flv_no_result", 32'(result_valid), 32'd0);
      // reset mid-operation with valid held high
      smectl_t = 1'b0;
      smectl_d = 4'd4;
      set_shares({32'h1, 32'h2, 32'h3, 32'h4});
      valid = 1'b1;
      step();
      valid = 1'b0;
      step();
      g_reset = 1'b1;
      valid = 1'b1;
      smectl_d = 4'd1;
      step();
      chk("rst_no_result", 32'(result_valid), 32'd0);
      chk("rst_result_zero", result, 32'd0);
      step();
      g_reset = 1'b0;
      valid = 1'b0;
      chk("rst_ready_after_release", 32'(ready), 32'd1);
      step();
      chk("rst_no_accept", 32'(result_valid), 32'd0);
      chk("rst_still_idle", 32'(ready), 32'd1);
      run_op(1'b1, 4'd3, {32'h0, 32'h3, 32'h2, 32'h1}, res, lat);
      chk("rst_next_result", res, 32'h6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
